// File: rtl/coin_score_if.sv
// Bundle between the coin collision instances and coin_score_tracker.
// The master side drives coin visibility and game events; the slave (tracker) drives score/status.
interface coin_score_if #(
    parameter int NUM_COINS = 4,
    parameter int SCORE_W   = 16
);
    localparam int CNT_W = $clog2(NUM_COINS + 1);

    logic [NUM_COINS-1:0] coin_visible_in;
    logic                 coins_loaded;
    logic                 pac_killed;

    logic [SCORE_W-1:0]   score;
    logic [CNT_W-1:0]     coins_left;
    logic [1:0]           lives;
    logic                 coin_eaten;
    logic                 level_clear;
    logic                 board_reset;
    logic                 game_over;

    modport master (
        output coin_visible_in, coins_loaded, pac_killed,
        input  score, coins_left, lives, coin_eaten, level_clear, board_reset, game_over
    );

    modport slave (
        input  coin_visible_in, coins_loaded, pac_killed,
        output score, coins_left, lives, coin_eaten, level_clear, board_reset, game_over
    );
endinterface

// File: rtl/coin_score_tracker.sv
// Scores coin visible->eaten edges, tracks lives/coins and sequences level clear and respawn.
// Optional feature: define COIN_SCORE_BONUS_EN to add LEVEL_BONUS on entry to the level-clear pause.
module coin_score_tracker #(
    parameter int NUM_COINS   = 4,
    parameter int COIN_POINTS = 10,
    parameter int SCORE_W     = 16,
    parameter int LIVES       = 3,
    parameter int CLEAR_HOLD  = 1024,
    parameter int LEVEL_BONUS = 100
) (
    input  logic         clk,
    input  logic         reset,
    coin_score_if.slave  bus
);
    localparam int CNT_W  = $clog2(NUM_COINS + 1);
    localparam int ACC_W  = SCORE_W + 8;
    localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);

    localparam logic [ACC_W-1:0]  SCORE_MAX = {{8{1'b0}}, {SCORE_W{1'b1}}};
    localparam logic [ACC_W-1:0]  POINTS    = ACC_W'(COIN_POINTS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CLEAR,
        S_RESPAWN,
        S_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_COINS-1:0] vis_q;
    logic                 kill_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           lives_q, lives_d;
    logic [CNT_W-1:0]     coins_left_q;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 coin_eaten_q, coin_eaten_d;
    logic                 level_clear_q, level_clear_d;
    logic                 board_reset_q, board_reset_d;

    logic [NUM_COINS-1:0] eaten;
    logic [CNT_W-1:0]     n_eaten;
    logic [ACC_W-1:0]     coin_inc;
    logic                 kill_edge;
    logic                 last_life_lost;
    logic                 board_empty;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_COINS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Widened add so the carry is visible, then clamp instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                   input logic [ACC_W-1:0]   inc);
        logic [ACC_W-1:0] sum;
        sum = ACC_W'(base) + inc;
        return (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_eaten
        assign eaten[gi] = vis_q[gi] & ~bus.coin_visible_in[gi];
    end

    assign n_eaten        = popcount(eaten);
    assign coin_inc       = ACC_W'(n_eaten) * POINTS;
    assign kill_edge      = bus.pac_killed & ~kill_q;
    assign last_life_lost = kill_edge && (lives_q <= 2'd1);
    assign board_empty    = (bus.coin_visible_in == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            vis_q         <= '0;
            kill_q        <= 1'b0;
            score_q       <= '0;
            lives_q       <= 2'(LIVES);
            coins_left_q  <= '0;
            hold_q        <= '0;
            coin_eaten_q  <= 1'b0;
            level_clear_q <= 1'b0;
            board_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vis_q         <= bus.coin_visible_in;
            kill_q        <= bus.pac_killed;
            score_q       <= score_d;
            lives_q       <= lives_d;
            coins_left_q  <= popcount(bus.coin_visible_in);
            hold_q        <= hold_d;
            coin_eaten_q  <= coin_eaten_d;
            level_clear_q <= level_clear_d;
            board_reset_q <= board_reset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.coins_loaded && (&bus.coin_visible_in)) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // A final kill outranks clearing the board in the same cycle.
                if (last_life_lost) begin
                    state_d = S_OVER;
                end else if (board_empty) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RESPAWN;
                end
            end
            S_RESPAWN: state_d = S_IDLE;
            S_OVER:    state_d = S_OVER;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        score_d       = score_q;
        lives_d       = lives_q;
        hold_d        = hold_q;
        coin_eaten_d  = 1'b0;
        level_clear_d = 1'b0;
        board_reset_d = 1'b0;
        case (state_q)
            S_PLAY: begin
                if (n_eaten != '0) begin
                    score_d      = sat_add(score_q, coin_inc);
                    coin_eaten_d = 1'b1;
                end
                if (kill_edge && (lives_q != 2'd0)) begin
                    lives_d = lives_q - 2'd1;
                end
                if (state_d == S_CLEAR) begin
                    level_clear_d = 1'b1;
                    hold_d        = '0;
                end
            end
            S_CLEAR: begin
`ifdef COIN_SCORE_BONUS_EN
                if (level_clear_q) begin
                    score_d = sat_add(score_q, ACC_W'(LEVEL_BONUS));
                end
`endif
                if (state_d == S_RESPAWN) begin
                    board_reset_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RESPAWN: hold_d = '0;
            default: ;
        endcase
    end

    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.coins_left  = coins_left_q;
    assign bus.coin_eaten  = coin_eaten_q;
    assign bus.level_clear = level_clear_q;
    assign bus.board_reset = board_reset_q;
    assign bus.game_over   = (state_q == S_OVER);
endmodule
